interrupt_controller: RTL and testbench

Memory-mapped interrupt controller between the CPU and the interrupt sources (timer at index 0, other peripherals above it).
- Edge-detects each source into a pending bit, applies a software mask, and selects the lowest-index active source.
- Holds a single Interrupt line to the CPU until software acknowledges the selected ID.
- Decodes its own registers on the shared data-memory bus alongside the timer.

---
 rtl/interrupt_controller_pkg.sv | 18 +
 rtl/interrupt_controller_prio_enc.sv | 23 ++
 rtl/interrupt_controller.sv | 129 ++++++++++++
 tb/tb_interrupt_controller.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared register addresses, FSM encoding and default sizing for the
// interrupt controller.
package interrupt_controller_pkg;

   localparam logic [31:0] ADDR_STATUS = 32'hffff_0080;
   localparam logic [31:0] ADDR_MASK   = 32'hffff_0084;
   localparam logic [31:0] ADDR_ACK    = 32'hffff_0088;
   localparam logic [31:0] ADDR_ID     = 32'hffff_008c;

   localparam int DEF_NUM_SRC = 4;
   localparam int DEF_IDW     = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } state_t;

endpackage

// File: rtl/interrupt_controller_prio_enc.sv
// Lowest-index-first priority encoder: reports the smallest set bit of req.
module prio_enc #(
   parameter int NUM_SRC = 4,
   parameter int IDW     = 4
) (
   input  logic [NUM_SRC-1:0] req,
   output logic [IDW-1:0]     id,
   output logic               valid
);

   // Scan downward so the lowest set index is the last one written.
   always_comb begin
      id    = '0;
      valid = 1'b0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            id    = IDW'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/interrupt_controller.sv
// Memory-mapped interrupt controller: edge-detected pending bits, software
// mask, lowest-index selection and a held Interrupt line released by ACK.
module interrupt_controller
   import interrupt_controller_pkg::*;
#(
   parameter int                 NUM_SRC    = DEF_NUM_SRC,
   parameter int                 IDW        = DEF_IDW,
   parameter logic [NUM_SRC-1:0] MASK_RESET = NUM_SRC'(1)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_in,
   input  logic [31:0]        address,
   input  logic [31:0]        data,
   input  logic               MemRead,
   input  logic               MemWrite,
   output logic [31:0]        rdata,
   output logic               CtrlAddress,
   output logic               Interrupt,
   output logic [IDW-1:0]     int_id
);

   state_t             state, state_next;
   logic [IDW-1:0]     int_id_next;
   logic [NUM_SRC-1:0] pending, pending_next, irq_prev, mask;
   logic [NUM_SRC-1:0] rise, active;
   logic [IDW-1:0]     enc_id;
   logic               enc_valid;
   logic               sel_status, sel_mask, sel_ack, sel_id;
   logic               wr_status, wr_mask, wr_ack, ack_hit;
   logic               unused_data;

   assign sel_status  = (address == ADDR_STATUS);
   assign sel_mask    = (address == ADDR_MASK);
   assign sel_ack     = (address == ADDR_ACK);
   assign sel_id      = (address == ADDR_ID);
   assign CtrlAddress = sel_status | sel_mask | sel_ack | sel_id;

   assign wr_status = MemWrite & sel_status;
   assign wr_mask   = MemWrite & sel_mask;
   assign wr_ack    = MemWrite & sel_ack;
   assign ack_hit   = wr_ack && (state == SERVE) && (data[IDW-1:0] == int_id);

   assign rise      = irq_in & ~irq_prev;
   assign active    = pending & mask;
   assign Interrupt = (state == SERVE);

   assign unused_data = ^data[31:NUM_SRC];

   prio_enc #(
      .NUM_SRC (NUM_SRC),
      .IDW     (IDW)
   ) u_prio_enc (
      .req   (active),
      .id    (enc_id),
      .valid (enc_valid)
   );

   // Clears are applied first so a fresh edge in the same cycle wins.
   always_comb begin
      pending_next = pending;
      if (wr_status)
         pending_next = pending_next & ~data[NUM_SRC-1:0];
      if (ack_hit) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (IDW'(i) == int_id)
               pending_next[i] = 1'b0;
         end
      end
      pending_next = pending_next | rise;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pending  <= '0;
         irq_prev <= '0;
         mask     <= MASK_RESET;
      end else begin
         pending  <= pending_next;
         irq_prev <= irq_in;
         if (wr_mask)
            mask <= data[NUM_SRC-1:0];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         int_id <= '0;
      end else begin
         state  <= state_next;
         int_id <= int_id_next;
      end
   end

   // int_id stays frozen for the whole service; only IDLE may reload it.
   always_comb begin
      state_next  = state;
      int_id_next = int_id;
      case (state)
         IDLE: begin
            if (enc_valid) begin
               state_next  = SERVE;
               int_id_next = enc_id;
            end
         end
         SERVE: begin
            if (ack_hit)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      rdata = '0;
      if (MemRead) begin
         if (sel_status)
            rdata[NUM_SRC-1:0] = pending;
         if (sel_mask)
            rdata[NUM_SRC-1:0] = mask;
         if (sel_id) begin
            rdata[31]      = (state == SERVE);
            rdata[IDW-1:0] = int_id;
         end
      end
   end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed scoreboard bench for interrupt_controller (NUM_SRC=4, IDW=4).
module tb_interrupt_controller;

   localparam logic [31:0] A_STATUS = 32'hffff_0080;
   localparam logic [31:0] A_MASK   = 32'hffff_0084;
   localparam logic [31:0] A_ACK    = 32'hffff_0088;
   localparam logic [31:0] A_ID     = 32'hffff_008c;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  irq_in;
   logic [31:0] address, data, rdata;
   logic        MemRead, MemWrite, CtrlAddress, Interrupt;
   logic [3:0]  int_id;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t        sb[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] r;

   interrupt_controller dut (
      .clock       (clock),
      .reset       (reset),
      .irq_in      (irq_in),
      .address     (address),
      .data        (data),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .rdata       (rdata),
      .CtrlAddress (CtrlAddress),
      .Interrupt   (Interrupt),
      .int_id      (int_id)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic expect_v(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic observe(input logic [31:0] obs);
      exp_t e;
      if (sb.size() == 0) begin
         miscompares++;
         $error("FAIL scoreboard_empty: observed %0h required an entry", obs);
      end else begin
         e = sb.pop_front();
         vectors++;
         assert (obs === e.val) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] exp, input logic [31:0] obs);
      expect_v(tag, exp);
      observe(obs);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] v);
      address = a;
      MemRead = 1'b1;
      #1;
      v = rdata;
      MemRead = 1'b0;
      address = '0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      address  = a;
      data     = d;
      MemWrite = 1'b1;
      tick();
      MemWrite = 1'b0;
      address  = '0;
      data     = '0;
   endtask

   initial begin
      reset = 1'b0; irq_in = '0; address = '0; data = '0;
      MemRead = 1'b0; MemWrite = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("reset_int", 32'd0, 32'(Interrupt));
      reset = 1'b1;
      tick();

      // Reset state
      chk("rst_interrupt", 32'd0, 32'(Interrupt));
      rd(A_MASK, r);   chk("rst_mask", 32'h1, r);
      rd(A_STATUS, r); chk("rst_status", 32'h0, r);
      rd(A_ID, r);     chk("rst_id", 32'h0, r);
      address = A_MASK;         #1; chk("ctrladdr_hit", 32'd1, 32'(CtrlAddress));
      address = 32'hffff_0090;  #1; chk("ctrladdr_miss", 32'd0, 32'(CtrlAddress));
      address = '0;

      // Single pulse on the timer
      irq_in = 4'b0001; tick(); irq_in = '0;
      rd(A_STATUS, r); chk("t0_status", 32'h1, r);
      chk("t0_int_early", 32'd0, 32'(Interrupt));
      tick();
      chk("t0_int", 32'd1, 32'(Interrupt));
      chk("t0_id", 32'd0, 32'(int_id));
      rd(A_ID, r); chk("t0_idreg", 32'h8000_0000, r);
      wr(A_ACK, 32'd0);
      chk("t0_ack_int", 32'd0, 32'(Interrupt));
      rd(A_STATUS, r); chk("t0_ack_status", 32'h0, r);

      // Two simultaneous sources, lowest index first
      wr(A_MASK, 32'hF);
      irq_in = 4'b1010; tick(); irq_in = '0; tick();
      chk("pr_int1", 32'd1, 32'(Interrupt));
      chk("pr_id1", 32'd1, 32'(int_id));
      wr(A_ACK, 32'd1);
      chk("pr_gap", 32'd0, 32'(Interrupt));
      rd(A_STATUS, r); chk("pr_status", 32'h8, r);
      tick();
      chk("pr_int3", 32'd1, 32'(Interrupt));
      chk("pr_id3", 32'd3, 32'(int_id));
      wr(A_ACK, 32'd3);
      chk("pr_done", 32'd0, 32'(Interrupt));
      rd(A_STATUS, r); chk("pr_status0", 32'h0, r);

      // Mismatched ACK, then ACK colliding with a new edge
      irq_in = 4'b0100; tick(); irq_in = '0; tick();
      chk("ak_int", 32'd1, 32'(Interrupt));
      chk("ak_id", 32'd2, 32'(int_id));
      wr(A_ACK, 32'd1);
      chk("ak_bad_int", 32'd1, 32'(Interrupt));
      chk("ak_bad_id", 32'd2, 32'(int_id));
      irq_in = 4'b0100;
      wr(A_ACK, 32'd2);
      irq_in = '0;
      chk("ak_exit", 32'd0, 32'(Interrupt));
      rd(A_STATUS, r); chk("ak_setwins", 32'h4, r);
      tick();
      chk("ak_re_int", 32'd1, 32'(Interrupt));
      chk("ak_re_id", 32'd2, 32'(int_id));
      wr(A_ACK, 32'd2);
      rd(A_STATUS, r); chk("ak_clean", 32'h0, r);

      // Masked source accumulates, unmask, W1C during service
      wr(A_MASK, 32'h1);
      irq_in = 4'b0100; tick(); irq_in = '0;
      rd(A_STATUS, r); chk("mk_status", 32'h4, r);
      chk("mk_int0", 32'd0, 32'(Interrupt));
      address = A_STATUS; #1; chk("mk_noread", 32'h0, rdata); address = '0;
      tick();
      chk("mk_int0b", 32'd0, 32'(Interrupt));
      wr(A_MASK, 32'hFFFF_FFF5);
      chk("mk_int_wr", 32'd0, 32'(Interrupt));
      rd(A_MASK, r); chk("mk_readback", 32'h5, r);
      tick();
      chk("mk_int1", 32'd1, 32'(Interrupt));
      chk("mk_id", 32'd2, 32'(int_id));
      wr(A_STATUS, 32'h4);
      rd(A_STATUS, r); chk("w1c_status", 32'h0, r);
      chk("w1c_int", 32'd1, 32'(Interrupt));
      rd(A_ACK, r); chk("ack_read0", 32'h0, r);
      rd(A_ID, r);  chk("w1c_idreg", 32'h8000_0002, r);
      wr(A_ACK, 32'd2);
      chk("w1c_ack", 32'd0, 32'(Interrupt));
      tick();
      chk("w1c_idle", 32'd0, 32'(Interrupt));

      // Asynchronous reset during service
      irq_in = 4'b0100; tick(); tick();
      chk("ar_int", 32'd1, 32'(Interrupt));
      reset = 1'b0; #1;
      chk("ar_int0", 32'd0, 32'(Interrupt));
      rd(A_STATUS, r); chk("ar_status", 32'h0, r);
      rd(A_MASK, r);   chk("ar_mask", 32'h1, r);
      rd(A_ID, r);     chk("ar_id", 32'h0, r);
      irq_in = '0; tick();
      chk("ar_hold", 32'd0, 32'(Interrupt));
      reset = 1'b1; tick();

      // Held level fires once; re-trigger needs fall then rise
      irq_in = 4'b0001; tick(); tick();
      chk("hl_int", 32'd1, 32'(Interrupt));
      wr(A_ACK, 32'd0);
      chk("hl_ack", 32'd0, 32'(Interrupt));
      repeat (3) tick();
      chk("hl_noretrig", 32'd0, 32'(Interrupt));
      rd(A_STATUS, r); chk("hl_status", 32'h0, r);
      irq_in = '0; tick();
      irq_in = 4'b0001; tick();
      rd(A_STATUS, r); chk("hl_rise_status", 32'h1, r);
      tick();
      chk("hl_rise_int", 32'd1, 32'(Interrupt));
      wr(A_ACK, 32'd0);
      irq_in = '0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
